// File: rtl/datapath_unit_if.sv
// datapath_unit_if
//   Bundles the control/status bus between the processor control FSM and
//   datapath_unit, plus the data-memory preload port.
//   master : control FSM / loader side (drives controls, observes results)
//   slave  : datapath side (consumes controls, drives results and flags)
//   Parameters: DW word width, RF_AW register-file address width,
//   DM_AW data-memory address width.
interface datapath_unit_if #(
  parameter int DW    = 16,
  parameter int RF_AW = 4,
  parameter int DM_AW = 8
);
  logic [DM_AW-1:0] D_addr;
  logic             D_wr;
  logic             RF_s;
  logic [RF_AW-1:0] RF_W_addr;
  logic             RF_W_en;
  logic [RF_AW-1:0] RF_Ra_addr;
  logic [RF_AW-1:0] RF_Rb_addr;
  logic [2:0]       ALU_s0;
  logic             ld_en;
  logic [DM_AW-1:0] ld_addr;
  logic [DW-1:0]    ld_data;
  logic [DW-1:0]    Ra_data;
  logic [DW-1:0]    Rb_data;
  logic [DW-1:0]    ALU_Q;
  logic [DW-1:0]    mem_rdata;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr,
           ALU_s0, ld_en, ld_addr, ld_data,
    input  Ra_data, Rb_data, ALU_Q, mem_rdata, flag_z, flag_c, flag_v
  );

  modport slave (
    input  D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr,
           ALU_s0, ld_en, ld_addr, ld_data,
    output Ra_data, Rb_data, ALU_Q, mem_rdata, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/datapath_unit.sv
// datapath_unit
//   Execution datapath for the processor control FSM: 16x16 register file
//   (2 async read ports, 1 sync write port), 8-function ALU and a 256-word
//   data memory with 1-cycle synchronous read and a preload write port.
//   Ports:
//     clk    rising-edge clock
//     Reset  synchronous reset, active-high (clears RF, mem_rdata, flags;
//            memory contents are kept)
//     dp     datapath_unit_if.slave control/status bus
//   Build option: define DATAPATH_FLAGS_EN to get registered Z/C/V flags
//   updated by ADD/SUB register writes; otherwise the flags are tied to 0.
module datapath_unit #(
  parameter int DW    = 16,
  parameter int RF_AW = 4,
  parameter int DM_AW = 8
) (
  input  logic            clk,
  input  logic            Reset,
  datapath_unit_if.slave  dp
);

  localparam int NREG = 1 << RF_AW;
  localparam int NMEM = 1 << DM_AW;

  logic [DW-1:0] rf_q  [NREG];
  logic [DW-1:0] mem_q [NMEM];
  logic [DW-1:0] mem_rdata_q;
  logic [DW-1:0] a_w;
  logic [DW-1:0] b_w;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] rf_wdata;

  assign a_w = rf_q[dp.RF_Ra_addr];
  assign b_w = rf_q[dp.RF_Rb_addr];

  always_comb begin
    alu_res = '0;
    case (dp.ALU_s0)
      3'b000:  alu_res = '0;
      3'b001:  alu_res = a_w + b_w;
      3'b010:  alu_res = a_w - b_w;
      3'b011:  alu_res = a_w;
      3'b100:  alu_res = a_w & b_w;
      3'b101:  alu_res = a_w | b_w;
      3'b110:  alu_res = a_w ^ b_w;
      default: alu_res = ~a_w;
    endcase
  end

  assign rf_wdata = dp.RF_s ? mem_rdata_q : alu_res;

  // Reads above are combinational off rf_q, so a same-cycle read of the
  // register being written returns the old value.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (dp.RF_W_en) begin
      rf_q[dp.RF_W_addr] <= rf_wdata;
    end
  end

  // Memory array has no reset; writes are still suppressed while Reset is
  // high. The preload port takes priority over a datapath STORE.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      if (dp.ld_en)     mem_q[dp.ld_addr] <= dp.ld_data;
      else if (dp.D_wr) mem_q[dp.D_addr]  <= a_w;
    end
  end

  // Read-first: on a same-address write the old word is returned.
  always_ff @(posedge clk) begin
    if (Reset) mem_rdata_q <= '0;
    else       mem_rdata_q <= mem_q[dp.D_addr];
  end

  assign dp.Ra_data   = a_w;
  assign dp.Rb_data   = b_w;
  assign dp.ALU_Q     = alu_res;
  assign dp.mem_rdata = mem_rdata_q;

`ifdef DATAPATH_FLAGS_EN
  logic [2:0] flags_q;
  logic [2:0] flags_d;
  logic       flag_upd;
  logic       is_sub;
  logic       add_c;
  logic       add_v;
  logic       sub_v;

  assign flag_upd = dp.RF_W_en && !dp.RF_s &&
                    (dp.ALU_s0 == 3'b001 || dp.ALU_s0 == 3'b010);
  assign is_sub   = dp.ALU_s0[1];

  // Carry into the MSB equals ~result[MSB] whenever the MSB operands differ.
  assign add_c = (a_w[DW-1] & b_w[DW-1]) |
                 ((a_w[DW-1] ^ b_w[DW-1]) & ~alu_res[DW-1]);
  assign add_v = (a_w[DW-1] == b_w[DW-1]) && (alu_res[DW-1] != a_w[DW-1]);
  assign sub_v = (a_w[DW-1] != b_w[DW-1]) && (alu_res[DW-1] != a_w[DW-1]);

  always_comb begin
    flags_d = flags_q;
    if (flag_upd) begin
      flags_d[2] = (alu_res == '0);
      flags_d[1] = is_sub ? (a_w >= b_w) : add_c;
      flags_d[0] = is_sub ? sub_v : add_v;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign dp.flag_z = flags_q[2];
  assign dp.flag_c = flags_q[1];
  assign dp.flag_v = flags_q[0];
`else
  assign dp.flag_z = 1'b0;
  assign dp.flag_c = 1'b0;
  assign dp.flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_unit.sv
module tb_datapath_unit;
  logic clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  datapath_unit_if dp_if ();

  datapath_unit u_dut (
    .clk   (clk),
    .Reset (Reset),
    .dp    (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DATAPATH_FLAGS_EN
  localparam bit FL_EN = 1'b1;
`else
  localparam bit FL_EN = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dp_if.D_wr    = 1'b0;
    dp_if.RF_W_en = 1'b0;
    dp_if.RF_s    = 1'b0;
    dp_if.ld_en   = 1'b0;
    dp_if.ALU_s0  = 3'b000;
  endtask

  // Stage a value in memory at 0xF0+rd, then LOAD it into register rd.
  task automatic load_reg(input logic [3:0] rd, input logic [15:0] val);
    idle();
    dp_if.ld_en   = 1'b1;
    dp_if.ld_addr = 8'hF0 + {4'h0, rd};
    dp_if.ld_data = val;
    tick();
    idle();
    dp_if.D_addr = 8'hF0 + {4'h0, rd};
    tick();
    dp_if.RF_s      = 1'b1;
    dp_if.RF_W_en   = 1'b1;
    dp_if.RF_W_addr = rd;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    dp_if.D_addr = 8'h00;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks++;
    if (dp_if.mem_rdata !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mem_rdata got=%h exp=0000", dp_if.mem_rdata);
    end
    for (int i = 0; i < 16; i++) begin
      dp_if.RF_Ra_addr = i[3:0];
      #1;
      n_checks++;
      if (dp_if.Ra_data !== 16'h0000) begin
        n_fail++; $display("FAIL reset_Ra_r%0d got=%h exp=0000", i, dp_if.Ra_data);
      end
    end
    n_checks++;
    if (dp_if.ALU_Q !== 16'h0000) begin
      n_fail++; $display("FAIL reset_alu got=%h exp=0000", dp_if.ALU_Q);
    end
    n_checks++;
    if ({dp_if.flag_z, dp_if.flag_c, dp_if.flag_v} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000",
                         {dp_if.flag_z, dp_if.flag_c, dp_if.flag_v});
    end
  endtask

  task automatic test_load();
    idle();
    dp_if.ld_en = 1'b1; dp_if.ld_addr = 8'h10; dp_if.ld_data = 16'h1234;
    tick();
    idle();
    dp_if.D_addr = 8'h10;
    tick();
    n_checks++;
    if (dp_if.mem_rdata !== 16'h1234) begin
      n_fail++; $display("FAIL load_rdata got=%h exp=1234", dp_if.mem_rdata);
    end
    dp_if.RF_s = 1'b1; dp_if.RF_W_en = 1'b1; dp_if.RF_W_addr = 4'd3;
    tick();
    idle();
    dp_if.RF_Ra_addr = 4'd3;
    #1;
    n_checks++;
    if (dp_if.Ra_data !== 16'h1234) begin
      n_fail++; $display("FAIL load_r3 got=%h exp=1234", dp_if.Ra_data);
    end
  endtask

  task automatic test_add();
    load_reg(4'd1, 16'hFFFF);
    load_reg(4'd2, 16'h0001);
    dp_if.RF_Ra_addr = 4'd1; dp_if.RF_Rb_addr = 4'd2; dp_if.ALU_s0 = 3'b001;
    #1;
    n_checks++;
    if (dp_if.ALU_Q !== 16'h0000) begin
      n_fail++; $display("FAIL add_aluq got=%h exp=0000", dp_if.ALU_Q);
    end
    dp_if.RF_s = 1'b0; dp_if.RF_W_en = 1'b1; dp_if.RF_W_addr = 4'd4;
    tick();
    idle();
    dp_if.RF_Ra_addr = 4'd4;
    #1;
    n_checks++;
    if (dp_if.Ra_data !== 16'h0000) begin
      n_fail++; $display("FAIL add_r4 got=%h exp=0000", dp_if.Ra_data);
    end
    n_checks++;
    if ({dp_if.flag_z, dp_if.flag_c, dp_if.flag_v} !== (FL_EN ? 3'b110 : 3'b000)) begin
      n_fail++; $display("FAIL add_flags got=%b exp=%b",
                         {dp_if.flag_z, dp_if.flag_c, dp_if.flag_v}, FL_EN ? 3'b110 : 3'b000);
    end
  endtask

  task automatic test_sub();
    load_reg(4'd1, 16'h8000);
    load_reg(4'd2, 16'h0001);
    dp_if.RF_Ra_addr = 4'd1; dp_if.RF_Rb_addr = 4'd2; dp_if.ALU_s0 = 3'b010;
    dp_if.RF_s = 1'b0; dp_if.RF_W_en = 1'b1; dp_if.RF_W_addr = 4'd5;
    tick();
    idle();
    dp_if.RF_Ra_addr = 4'd5;
    #1;
    n_checks++;
    if (dp_if.Ra_data !== 16'h7FFF) begin
      n_fail++; $display("FAIL sub_r5 got=%h exp=7fff", dp_if.Ra_data);
    end
    n_checks++;
    if ({dp_if.flag_z, dp_if.flag_c, dp_if.flag_v} !== (FL_EN ? 3'b011 : 3'b000)) begin
      n_fail++; $display("FAIL sub_flags got=%b exp=%b",
                         {dp_if.flag_z, dp_if.flag_c, dp_if.flag_v}, FL_EN ? 3'b011 : 3'b000);
    end
    // Non-ADD/SUB write must leave flags alone.
    dp_if.RF_Ra_addr = 4'd2; dp_if.ALU_s0 = 3'b011;
    dp_if.RF_W_en = 1'b1; dp_if.RF_W_addr = 4'd9;
    tick();
    idle();
    n_checks++;
    if ({dp_if.flag_z, dp_if.flag_c, dp_if.flag_v} !== (FL_EN ? 3'b011 : 3'b000)) begin
      n_fail++; $display("FAIL flags_hold got=%b exp=%b",
                         {dp_if.flag_z, dp_if.flag_c, dp_if.flag_v}, FL_EN ? 3'b011 : 3'b000);
    end
  endtask

  task automatic test_alu_funcs();
    logic [15:0] exp_q [8];
    exp_q = '{16'h0000, 16'h6A2C, 16'h4A4C, 16'h5A3C,
              16'h0A30, 16'h5FFC, 16'h55CC, 16'hA5C3};
    load_reg(4'd7, 16'h5A3C);
    load_reg(4'd8, 16'h0FF0);
    dp_if.RF_Ra_addr = 4'd7; dp_if.RF_Rb_addr = 4'd8;
    for (int f = 0; f < 8; f++) begin
      dp_if.ALU_s0 = f[2:0];
      #1;
      n_checks++;
      if (dp_if.ALU_Q !== exp_q[f]) begin
        n_fail++; $display("FAIL alu_fn%0d got=%h exp=%h", f, dp_if.ALU_Q, exp_q[f]);
      end
    end
    idle();
  endtask

  task automatic test_store();
    // R5 holds 0x7FFF from test_sub; preload beats STORE.
    idle();
    dp_if.RF_Ra_addr = 4'd5; dp_if.D_addr = 8'h20; dp_if.D_wr = 1'b1;
    dp_if.ld_en = 1'b1; dp_if.ld_addr = 8'h20; dp_if.ld_data = 16'hBEEF;
    tick();
    idle();
    tick();
    n_checks++;
    if (dp_if.mem_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL store_ld_wins got=%h exp=beef", dp_if.mem_rdata);
    end
    // Read-first on same address, plain STORE.
    dp_if.ld_en = 1'b1; dp_if.ld_addr = 8'h22; dp_if.ld_data = 16'h1111;
    tick();
    idle();
    dp_if.D_addr = 8'h22; dp_if.D_wr = 1'b1;
    tick();
    dp_if.D_wr = 1'b0;
    n_checks++;
    if (dp_if.mem_rdata !== 16'h1111) begin
      n_fail++; $display("FAIL store_read_first got=%h exp=1111", dp_if.mem_rdata);
    end
    tick();
    n_checks++;
    if (dp_if.mem_rdata !== 16'h7FFF) begin
      n_fail++; $display("FAIL store_data got=%h exp=7fff", dp_if.mem_rdata);
    end
  endtask

  task automatic test_back_to_back();
    // STORE and RF write of the same register in one cycle.
    idle();
    dp_if.RF_Ra_addr = 4'd5; dp_if.D_addr = 8'h23; dp_if.D_wr = 1'b1;
    dp_if.ALU_s0 = 3'b000; dp_if.RF_W_en = 1'b1; dp_if.RF_W_addr = 4'd5;
    tick();
    idle();
    tick();
    n_checks++;
    if (dp_if.mem_rdata !== 16'h7FFF) begin
      n_fail++; $display("FAIL store_old_rf got=%h exp=7fff", dp_if.mem_rdata);
    end
    n_checks++;
    if (dp_if.Ra_data !== 16'h0000) begin
      n_fail++; $display("FAIL store_rf_written got=%h exp=0000", dp_if.Ra_data);
    end
    // Same-cycle read of the register being written.
    load_reg(4'd6, 16'hAAAA);
    dp_if.RF_Ra_addr = 4'd6; dp_if.ALU_s0 = 3'b111;
    dp_if.RF_W_en = 1'b1; dp_if.RF_W_addr = 4'd6;
    #1;
    n_checks++;
    if (dp_if.Ra_data !== 16'hAAAA) begin
      n_fail++; $display("FAIL wr_same_cycle got=%h exp=aaaa", dp_if.Ra_data);
    end
    tick();
    idle();
    n_checks++;
    if (dp_if.Ra_data !== 16'h5555) begin
      n_fail++; $display("FAIL wr_next_cycle got=%h exp=5555", dp_if.Ra_data);
    end
  endtask

  task automatic test_reset_mid_load();
    idle();
    dp_if.D_addr = 8'h10;
    dp_if.RF_s = 1'b1; dp_if.RF_W_en = 1'b1; dp_if.RF_W_addr = 4'd3;
    dp_if.ld_en = 1'b1; dp_if.ld_addr = 8'h10; dp_if.ld_data = 16'hDEAD;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    idle();
    n_checks++;
    if (dp_if.mem_rdata !== 16'h0000) begin
      n_fail++; $display("FAIL rst_mid_rdata got=%h exp=0000", dp_if.mem_rdata);
    end
    dp_if.RF_Ra_addr = 4'd3;
    #1;
    n_checks++;
    if (dp_if.Ra_data !== 16'h0000) begin
      n_fail++; $display("FAIL rst_mid_r3 got=%h exp=0000", dp_if.Ra_data);
    end
    n_checks++;
    if ({dp_if.flag_z, dp_if.flag_c, dp_if.flag_v} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_flags got=%b exp=000",
                         {dp_if.flag_z, dp_if.flag_c, dp_if.flag_v});
    end
    tick();
    n_checks++;
    if (dp_if.mem_rdata !== 16'h1234) begin
      n_fail++; $display("FAIL rst_mem_kept got=%h exp=1234", dp_if.mem_rdata);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    dp_if.D_addr = '0; dp_if.RF_W_addr = '0;
    dp_if.RF_Ra_addr = '0; dp_if.RF_Rb_addr = '0;
    dp_if.ld_addr = '0; dp_if.ld_data = '0;
    idle();
    #2;
    test_reset();
    test_load();
    test_add();
    test_sub();
    test_alu_funcs();
    test_store();
    test_back_to_back();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
